aux_cmd_engine: RTL

Command initiator on the CalPC side of the auxiliary host link. Drives the aux_io control interface as its master: pulls 32-bit command words that the host wrote into the pipe-in FIFO, executes register reads/writes on a local register bus, and pushes acknowledge/response words back toward the host pipe-out FIFO. Sits between aux_io and the calibration register file.

---
 rtl/aux_cmd_engine.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/aux_cmd_engine.sv
// aux_cmd_engine: fetches host command words through aux_io, runs them as register
// reads/writes on the local register bus and returns response words to the host.
module aux_cmd_engine #(
    parameter logic [16:0] AUX_ADDR       = 17'd0,
    parameter int unsigned REG_RD_LATENCY = 1,
    parameter logic [15:0] PING_MAGIC     = 16'hCA1B
) (
    input  logic        clk,
    input  logic        reset,
    output logic        aux_read_req,
    output logic        aux_write_req,
    output logic [31:0] aux_data_write,
    input  logic [31:0] aux_data_read,
    output logic [16:0] aux_address,
    input  logic        aux_busy,
    output logic        reg_wr_en,
    output logic        reg_rd_en,
    output logic [15:0] reg_addr,
    output logic [31:0] reg_wr_data,
    input  logic [31:0] reg_rd_data,
    output logic [15:0] cmd_count,
    output logic [7:0]  err_count,
    output logic        active
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned LAT_W  = 3;

    localparam logic [3:0] OPC_NOP   = 4'h0;
    localparam logic [3:0] OPC_WRITE = 4'h1;
    localparam logic [3:0] OPC_READ  = 4'h2;
    localparam logic [3:0] OPC_PING  = 4'h3;

    localparam logic [15:0] ST_OK  = 16'h0000;
    localparam logic [15:0] ST_BAD = 16'h0001;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_WAIT,
        S_DECODE,
        S_REG_WR,
        S_RD_STROBE,
        S_RD_LAT
    } state_t;

    // Which aux transaction the shared ISSUE/SETTLE/WAIT sequence is running.
    typedef enum logic [1:0] {
        B_HDR,
        B_PAYLOAD,
        B_RESP,
        B_DATA
    } bus_t;

    state_t              state_q, state_d;
    bus_t                bus_q, bus_d;
    logic [WORD_W-1:0]   hdr_q, hdr_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [LAT_W-1:0]    lat_q, lat_d;

    logic                read_req_d;
    logic                write_req_d;
    logic [WORD_W-1:0]   data_write_d;
    logic                wr_en_d;
    logic                rd_en_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [WORD_W-1:0]   wr_data_d;
    logic [15:0]         cmd_count_d;
    logic [7:0]          err_count_d;
    logic                active_d;
    logic                finish;

    logic [3:0]          opcode;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   base;
    logic [CNT_W-1:0]    idx_inc;
    logic                is_bad;

    assign opcode      = hdr_q[31:28];
    assign cnt         = hdr_q[23:16];
    assign base        = hdr_q[15:0];
    assign idx_inc     = idx_q + CNT_W'(1);
    assign is_bad      = (opcode > OPC_PING);
    assign aux_address = AUX_ADDR;

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            bus_q          <= B_HDR;
            hdr_q          <= '0;
            idx_q          <= '0;
            lat_q          <= '0;
            aux_read_req   <= 1'b0;
            aux_write_req  <= 1'b0;
            aux_data_write <= '0;
            reg_wr_en      <= 1'b0;
            reg_rd_en      <= 1'b0;
            reg_addr       <= '0;
            reg_wr_data    <= '0;
            cmd_count      <= '0;
            err_count      <= '0;
            active         <= 1'b0;
        end else begin
            state_q        <= state_d;
            bus_q          <= bus_d;
            hdr_q          <= hdr_d;
            idx_q          <= idx_d;
            lat_q          <= lat_d;
            aux_read_req   <= read_req_d;
            aux_write_req  <= write_req_d;
            aux_data_write <= data_write_d;
            reg_wr_en      <= wr_en_d;
            reg_rd_en      <= rd_en_d;
            reg_addr       <= addr_d;
            reg_wr_data    <= wr_data_d;
            cmd_count      <= cmd_count_d;
            err_count      <= err_count_d;
            active         <= active_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        bus_d        = bus_q;
        hdr_d        = hdr_q;
        idx_d        = idx_q;
        lat_d        = lat_q;
        read_req_d   = 1'b0;
        write_req_d  = 1'b0;
        data_write_d = aux_data_write;
        wr_en_d      = 1'b0;
        rd_en_d      = 1'b0;
        addr_d       = reg_addr;
        wr_data_d    = reg_wr_data;
        finish       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!aux_busy) begin
                    read_req_d = 1'b1;
                    bus_d      = B_HDR;
                    state_d    = S_SETTLE;
                end
            end
            S_ISSUE: begin
                if (!aux_busy) begin
                    if (bus_q == B_PAYLOAD) begin
                        read_req_d = 1'b1;
                    end else begin
                        write_req_d = 1'b1;
                    end
                    state_d = S_SETTLE;
                end
            end
            // aux_io may raise busy only one cycle after seeing the request.
            S_SETTLE: state_d = S_WAIT;
            S_WAIT: begin
                if (!aux_busy) begin
                    unique case (bus_q)
                        B_HDR: begin
                            hdr_d   = aux_data_read;
                            state_d = S_DECODE;
                        end
                        B_PAYLOAD: begin
                            wr_data_d = aux_data_read;
                            addr_d    = base + ADDR_W'(idx_q);
                            wr_en_d   = 1'b1;
                            state_d   = S_REG_WR;
                        end
                        B_RESP: begin
                            if (opcode == OPC_READ && cnt != '0) begin
                                idx_d   = '0;
                                addr_d  = base;
                                rd_en_d = 1'b1;
                                state_d = S_RD_STROBE;
                            end else begin
                                finish = 1'b1;
                            end
                        end
                        B_DATA: begin
                            if (idx_inc == cnt) begin
                                finish = 1'b1;
                            end else begin
                                idx_d   = idx_inc;
                                addr_d  = base + ADDR_W'(idx_inc);
                                rd_en_d = 1'b1;
                                state_d = S_RD_STROBE;
                            end
                        end
                    endcase
                end
            end
            S_DECODE: begin
                idx_d   = '0;
                bus_d   = B_RESP;
                state_d = S_ISSUE;
                case (opcode)
                    OPC_NOP: finish = 1'b1;
                    OPC_WRITE: begin
                        if (cnt != '0) begin
                            bus_d = B_PAYLOAD;
                        end else begin
                            data_write_d = {hdr_q[31:16], ST_OK};
                        end
                    end
                    OPC_READ: data_write_d = {hdr_q[31:16], ST_OK};
                    OPC_PING: data_write_d = {hdr_q[31:16], PING_MAGIC};
                    default:  data_write_d = {hdr_q[31:16], ST_BAD};
                endcase
            end
            S_REG_WR: begin
                state_d = S_ISSUE;
                if (idx_inc == cnt) begin
                    data_write_d = {hdr_q[31:16], ST_OK};
                    bus_d        = B_RESP;
                end else begin
                    idx_d = idx_inc;
                    bus_d = B_PAYLOAD;
                end
            end
            S_RD_STROBE: begin
                lat_d   = LAT_W'(1);
                state_d = S_RD_LAT;
            end
            // Sample read data exactly REG_RD_LATENCY cycles after the strobe.
            S_RD_LAT: begin
                if (lat_q == LAT_W'(REG_RD_LATENCY)) begin
                    data_write_d = reg_rd_data;
                    bus_d        = B_DATA;
                    state_d      = S_ISSUE;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (finish) begin
            state_d = S_IDLE;
        end

        cmd_count_d = cmd_count + (finish ? 16'd1 : 16'd0);
        err_count_d = err_count;
        if (finish && is_bad && err_count != 8'hFF) begin
            err_count_d = err_count + 8'd1;
        end
        active_d = (state_d != S_IDLE);
    end

endmodule
